// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and constants for the mem_access_ctrl load/store sequencer.
package mem_ctrl_pkg;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } mac_state_t;

  // Registered copy of an accepted request; waddr is always the odd word address.
  typedef struct packed {
    logic              we;
    logic              is_byte;
    logic              is_signed;
    logic              lane;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } mac_req_t;

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshake plus the memory-side bus of mem_access_ctrl.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// resp_valid is a single-cycle pulse with no backpressure.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = mem_ctrl_pkg::ADDR_W,
    parameter int DATA_W = mem_ctrl_pkg::DATA_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_byte;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_we;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, mem_data_out,
        input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_data_in, mem_we
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata, mem_data_out,
        output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_data_in, mem_we
    );
endinterface

// File: rtl/mem_access_ctrl_byte_lane.sv
// Byte lane helper: selects a lane with zero/sign extension, and builds the
// store word (merged byte for byte stores, raw data for word stores).
module mem_byte_lane (
    input  logic [15:0] i_word,
    input  logic        i_lane,
    input  logic        i_signed,
    input  logic        i_is_byte,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_ext,
    output logic [15:0] o_store
);
    logic [7:0] w_sel;

    always_comb begin
        w_sel   = i_lane ? i_word[15:8] : i_word[7:0];
        o_ext   = {{8{i_signed & w_sel[7]}}, w_sel};
        o_store = i_wdata;
        if (i_is_byte) begin
            o_store = i_lane ? {i_wdata[7:0], i_word[7:0]} : {i_word[15:8], i_wdata[7:0]};
        end
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer in front of the 16-bit byte-addressed memory.
// Optional MEM_ACCESS_STATS_EN adds saturating load/store/error counters.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int READ_WAIT = 1,
    parameter int ADDR_W    = mem_ctrl_pkg::ADDR_W,
    parameter int DATA_W    = mem_ctrl_pkg::DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_access_ctrl_if.slave   bus,
    output mac_state_t         o_dbg_state
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]        stat_loads,
    output logic [15:0]        stat_stores,
    output logic [15:0]        stat_errs
`endif
);
    localparam logic [3:0] LP_WAIT_INIT = 4'(READ_WAIT - 1);

    mac_state_t        r_state;
    mac_state_t        w_next;
    mac_req_t          r_req;
    logic [3:0]        r_cnt;
    logic [DATA_W-1:0] r_mem_data_in;
    logic              r_mem_we;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              w_accept;
    logic              w_misalign;
    logic              w_rd_last;
    logic [15:0]       w_ext;
    logic [15:0]       w_store;

    assign w_accept   = bus.req_valid && (r_state == IDLE);
    assign w_misalign = !bus.req_byte && !bus.req_addr[0];
    assign w_rd_last  = (r_state == RD) && (r_cnt == 4'd0);

    mem_byte_lane u_lane (
        .i_word    (bus.mem_data_out),
        .i_lane    (r_req.lane),
        .i_signed  (r_req.is_signed),
        .i_is_byte (r_req.is_byte),
        .i_wdata   (r_req.wdata),
        .o_ext     (w_ext),
        .o_store   (w_store)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_misalign)                        w_next = RESP;
                    else if (bus.req_we && !bus.req_byte)  w_next = WR;
                    else                                   w_next = RD;
                end
            end
            RD:      if (r_cnt == 4'd0) w_next = r_req.we ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Strobes are registered from the next state so they come straight off flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req         <= '0;
            r_cnt         <= '0;
            r_mem_data_in <= '0;
            r_mem_we      <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_err    <= 1'b0;
            r_resp_rdata  <= '0;
        end else begin
            r_mem_we     <= (w_next == WR);
            r_resp_valid <= (w_next == RESP);
            if (w_accept) begin
                r_req.we        <= bus.req_we;
                r_req.is_byte   <= bus.req_byte;
                r_req.is_signed <= bus.req_signed;
                r_req.lane      <= bus.req_addr[0];
                r_req.waddr     <= {bus.req_addr[ADDR_W-1:1], 1'b1};
                r_req.wdata     <= bus.req_wdata;
                r_mem_data_in   <= bus.req_wdata;
                if (w_misalign) begin
                    r_resp_err   <= 1'b1;
                    r_resp_rdata <= '0;
                end
            end
            if (w_next == RD && r_state != RD) r_cnt <= LP_WAIT_INIT;
            else if (r_state == RD && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
            if (w_rd_last) begin
                if (r_req.we) begin
                    r_mem_data_in <= w_store;
                end else begin
                    r_resp_rdata <= r_req.is_byte ? w_ext : bus.mem_data_out;
                    r_resp_err   <= 1'b0;
                end
            end
            if (r_state == WR) r_resp_err <= 1'b0;
        end
    end

    assign bus.req_ready   = (r_state == IDLE);
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_err    = r_resp_err;
    assign bus.resp_rdata  = r_resp_rdata;
    assign bus.mem_addr    = r_req.waddr;
    assign bus.mem_data_in = r_mem_data_in;
    assign bus.mem_we      = r_mem_we;
    assign o_dbg_state     = r_state;

`ifdef MEM_ACCESS_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_loads  <= '0;
            stat_stores <= '0;
            stat_errs   <= '0;
        end else if (r_state == RESP) begin
            if (r_resp_err) begin
                if (stat_errs != 16'hFFFF) stat_errs <= stat_errs + 16'd1;
            end else if (r_req.we) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a byte-array memory model (READ_WAIT=3).
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  mac_state_t dbg_state;
  int n_chk = 0;
  int n_pass = 0;
  logic [15:0] exp_q[$];
  logic [7:0] mem [0:16383];

`ifdef MEM_ACCESS_STATS_EN
  logic [15:0] stat_loads, stat_stores, stat_errs;
`endif

  mem_access_ctrl_if #(.ADDR_W(14), .DATA_W(16)) bus ();

  mem_access_ctrl #(.READ_WAIT(RW), .ADDR_W(14), .DATA_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef MEM_ACCESS_STATS_EN
    ,
    .stat_loads  (stat_loads),
    .stat_stores (stat_stores),
    .stat_errs   (stat_errs)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: word at odd A = {mem[A], mem[A-1]}
  assign bus.mem_data_out = {mem[bus.mem_addr], mem[bus.mem_addr - 14'd1]};
  always @(posedge clk) begin
    if (bus.mem_we) begin
      mem[bus.mem_addr]         <= bus.mem_data_in[15:8];
      mem[bus.mem_addr - 14'd1] <= bus.mem_data_in[7:0];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_req(input logic we, input logic bt, input logic sg, input logic [13:0] addr,
                        input logic [15:0] wd, output int lat, output logic [15:0] rd,
                        output logic er, output logic we_seen, output logic [15:0] wr_data);
    lat = 0; rd = '0; er = 1'b0; we_seen = 1'b0; wr_data = '0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_byte = bt;
    bus.req_signed = sg; bus.req_addr = addr; bus.req_wdata = wd;
    check("ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("busy_after_accept", bus.req_ready, 0);
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (bus.mem_we) begin we_seen = 1'b1; wr_data = bus.mem_data_in; end
      if (bus.resp_valid) begin
        lat = i; rd = bus.resp_rdata; er = bus.resp_err;
        break;
      end
    end
    if (lat == 0) check("resp_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
      check("resp_one_cycle", bus.resp_valid, 0);
    end
  endtask

  task automatic load_chk(input string tag, input logic bt, input logic sg, input logic [13:0] addr,
                          input logic [15:0] exp, input int exp_lat);
    int lat; logic [15:0] rd, wr_data; logic er, ws;
    exp_q.push_back(exp);
    do_req(1'b0, bt, sg, addr, 16'h0, lat, rd, er, ws, wr_data);
    check({tag, "_rdata"}, rd, exp_q.pop_front());
    check({tag, "_err"}, er, 0);
    check({tag, "_lat"}, lat, exp_lat);
  endtask

  initial begin
    int lat; logic [15:0] rd, wr_data; logic er, ws; int pulses;
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_byte = 1'b0;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_ready", bus.req_ready, 1);
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_din", bus.mem_data_in, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err", bus.resp_err, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);

    do_req(1'b1, 1'b0, 1'b0, 14'h0011, 16'hBEEF, lat, rd, er, ws, wr_data);
    check("wst_lat", lat, 2);
    check("wst_err", er, 0);
    check("wst_we", ws, 1);
    check("wst_mem_hi", mem[14'h11], 8'hBE);
    check("wst_mem_lo", mem[14'h10], 8'hEF);
    load_chk("wld", 1'b0, 1'b0, 14'h0011, 16'hBEEF, RW + 1);

    do_req(1'b1, 1'b1, 1'b0, 14'h0010, 16'h005A, lat, rd, er, ws, wr_data);
    check("bst_lat", lat, RW + 2);
    check("bst_wdata", wr_data, 16'hBE5A);
    load_chk("reload", 1'b0, 1'b0, 14'h0011, 16'hBE5A, RW + 1);
    load_chk("bld_s_hi", 1'b1, 1'b1, 14'h0011, 16'hFFBE, RW + 1);
    load_chk("bld_u_hi", 1'b1, 1'b0, 14'h0011, 16'h00BE, RW + 1);
    load_chk("bld_s_lo", 1'b1, 1'b1, 14'h0010, 16'h005A, RW + 1);

    do_req(1'b1, 1'b1, 1'b0, 14'h0011, 16'hFF80, lat, rd, er, ws, wr_data);
    check("bst_hi_wdata", wr_data, 16'h805A);
    load_chk("bld_s_80", 1'b1, 1'b1, 14'h0011, 16'hFF80, RW + 1);

    do_req(1'b0, 1'b0, 1'b0, 14'h0000, 16'h0, lat, rd, er, ws, wr_data);
    check("mis_ld_err", er, 1);
    check("mis_ld_rdata", rd, 0);
    check("mis_ld_lat", lat, 1);
    check("mis_ld_we", ws, 0);
    do_req(1'b1, 1'b0, 1'b0, 14'h0012, 16'h1234, lat, rd, er, ws, wr_data);
    check("mis_st_err", er, 1);
    check("mis_st_lat", lat, 1);
    check("mis_st_we", ws, 0);
    check("mis_st_mem", {mem[14'h13], mem[14'h12]}, 16'h0000);
    load_chk("after_err", 1'b0, 1'b0, 14'h0011, 16'h805A, RW + 1);

`ifdef MEM_ACCESS_STATS_EN
    @(posedge clk); #1;
    check("stat_loads", stat_loads, 7);
    check("stat_stores", stat_stores, 3);
    check("stat_errs", stat_errs, 2);
`endif

    // Reset asserted while a byte store is in its WR cycle
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_byte = 1'b1;
    bus.req_signed = 1'b0; bus.req_addr = 14'h0020; bus.req_wdata = 16'h0033;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    ws = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_we) begin ws = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rstwr_we_seen", ws, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstwr_we_drop", bus.mem_we, 0);
    check("rstwr_state", dbg_state, IDLE);
    check("rstwr_mem_addr", bus.mem_addr, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid) pulses++;
    end
    check("rstwr_no_resp", pulses, 0);
    check("rstwr_ready", bus.req_ready, 1);
`ifdef MEM_ACCESS_STATS_EN
    check("rstwr_stat_loads", stat_loads, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
